imm_seq_ctrl: RTL



---
 rtl/imm_seq_pkg.sv | 20 ++
 rtl/imm_seq_ctrl_if.sv | 25 ++
 rtl/imm_ext_unit.sv | 24 ++
 rtl/imm_seq_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/imm_seq_pkg.sv
// Shared types and constants for the immediate-assembly sequencer.
// No logic here; consumed by the controller and the extension unit.
// Mode and state encodings are fixed so other blocks can decode them.
package imm_seq_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SEXT  = 2'b00;
  localparam mode_t MODE_ZEXT  = 2'b01;
  localparam mode_t MODE_UPPER = 2'b10;
  localparam mode_t MODE_LONG  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HW1  = 2'd1,
    HW2  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/imm_seq_ctrl_if.sv
// Command, halfword and immediate handshake bundle for imm_seq_ctrl.
// Pure wiring, no latency.
// master drives commands/halfwords and consumes the immediate; slave is the controller.
interface imm_seq_ctrl_if #(parameter int CNT_W = 16);
  logic             start;
  logic [1:0]       mode;
  logic [15:0]      hw_data;
  logic             hw_valid;
  logic             hw_ready;
  logic [31:0]      imm;
  logic             imm_valid;
  logic             imm_ready;
  logic             busy;
  logic [CNT_W-1:0] imm_count;

  modport master (
    output start, mode, hw_data, hw_valid, imm_ready,
    input  hw_ready, imm, imm_valid, busy, imm_count
  );

  modport slave (
    input  start, mode, hw_data, hw_valid, imm_ready,
    output hw_ready, imm, imm_valid, busy, imm_count
  );
endinterface

// File: rtl/imm_ext_unit.sv
// Widens one instruction halfword to a 32-bit immediate according to mode.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is captured.
module imm_ext_unit
  import imm_seq_pkg::*;
(
  input  mode_t       mode,
  input  logic [15:0] hw_data,
  output logic [31:0] ext
);

  // Long mode places the halfword high, same as upper; the low half arrives later.
  always_comb begin
    ext = {16'h0000, hw_data};
    case (mode)
      MODE_SEXT:  ext = {{16{hw_data[15]}}, hw_data};
      MODE_ZEXT:  ext = {16'h0000, hw_data};
      MODE_UPPER: ext = {hw_data, 16'h0000};
      MODE_LONG:  ext = {hw_data, 16'h0000};
      default:    ext = {16'h0000, hw_data};
    endcase
  end

endmodule

// File: rtl/imm_seq_ctrl.sv
// Assembles one 32-bit immediate per command from 1 or 2 fetched halfwords.
// imm_valid rises the cycle after the last halfword handshake (3 cycles min short, 4 long).
// hw stalls hold HW1/HW2 indefinitely; imm is held stable until imm_ready.
module imm_seq_ctrl
  import imm_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  imm_seq_ctrl_if.slave bus
);

  state_t           state;
  mode_t            mode_q;
  logic [31:0]      imm_q;
  logic             imm_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      ext;
  logic             hw_rdy;
  logic             hw_fire;
  logic             imm_fire;

  imm_ext_unit u_ext (
    .mode    (mode_q),
    .hw_data (bus.hw_data),
    .ext     (ext)
  );

  // Halfwords are only accepted while waiting for them; never in the start cycle.
  assign hw_rdy   = (state == HW1) || (state == HW2);
  assign hw_fire  = bus.hw_valid && hw_rdy;
  assign imm_fire = imm_valid_q && bus.imm_ready;

  assign bus.hw_ready  = hw_rdy;
  assign bus.imm       = imm_q;
  assign bus.imm_valid = imm_valid_q;
  assign bus.busy      = busy_q;
  assign bus.imm_count = cnt_q;

  // Sequencer: state, mode latch, immediate register, delivery counter and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= MODE_SEXT;
      imm_q       <= 32'h0;
      imm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            state  <= HW1;
            busy_q <= 1'b1;
          end
        end
        HW1: begin
          if (hw_fire) begin
            if (mode_q == MODE_LONG) begin
              // Keep the low half untouched; it is filled by the second halfword.
              imm_q[31:16] <= ext[31:16];
              state        <= HW2;
            end else begin
              imm_q       <= ext;
              imm_valid_q <= 1'b1;
              state       <= OUT;
            end
          end
        end
        HW2: begin
          if (hw_fire) begin
            imm_q[15:0] <= bus.hw_data;
            imm_valid_q <= 1'b1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (imm_fire) begin
            cnt_q       <= cnt_q + CNT_W'(1);
            imm_valid_q <= 1'b0;
            // A start on the delivery cycle chains straight into the next command.
            if (bus.start) begin
              mode_q <= bus.mode;
              state  <= HW1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          imm_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule
